clk_div_scheduler: RTL
======================

// Module: clk_div_scheduler
// PURPOSE
//  Shared programmable clock-divider bank: NCH independent divide-by-2(P+1) channels, periods
//  reprogrammed at run time through a valid/ready config port. Updates are applied only at a
//  channel's wrap boundary, so derived clocks never glitch or produce short half-periods.
//  Sits between the 100 MHz board CLOCK and the display/audio/debounce logic that needs slow clocks.
// PARAMETERS
//  NCH            4     number of divider channels (1..8)
//  WIDTH          32    counter/period width in bits
//  DEFAULT_PERIOD 2499  reset terminal count for every channel (100 MHz -> 20 kHz square wave)
// PORTS
//  CLOCK        in   1             system clock; all logic on rising edge
//  RESET        in   1             asynchronous, active-high reset
//  chan_en      in   NCH           per-channel run enable
//  cfg_valid    in   1             config request valid
//  cfg_ready    out  1             config slot free; transfer on cfg_valid & cfg_ready
//  cfg_chan     in   $clog2(NCH)   target channel of the request
//  cfg_period   in   WIDTH         new terminal count P for the target channel
//  cfg_done     out  1             one-cycle pulse: pending period was committed
//  tick         out  NCH           one-cycle pulse per channel wrap
//  clk_out      out  NCH           divided square wave per channel
// BEHAVIOUR
//  Reset (async, immediate): cnt[i]=0, period[i]=DEFAULT_PERIOD, clk_out=0, tick=0, cfg_done=0,
//   FSM=IDLE, cfg_ready=1, pending chan/period cleared. A request pending at reset is discarded.
//  Channel i, chan_en[i]=1, every cycle:
//   - cnt[i]==period[i]: cnt[i]<=0, clk_out[i]<=~clk_out[i], tick[i]<=1 (visible next cycle).
//   - cnt[i]> period[i] (defensive): treat as wrap, same as above.
//   - else cnt[i]<=cnt[i]+1, tick[i]<=0.
//   - Output period = 2(P+1) CLOCK cycles; P=0 -> clk_out toggles every cycle, tick constantly 1.
//   - P=2^WIDTH-1 legal; no overflow since wrap occurs at equality.
//  Channel i, chan_en[i]=0: cnt[i]<=0, tick[i]<=0, clk_out[i] holds its level.
//   Re-enable: first tick after exactly P+1 enabled cycles.
//  Config FSM (states IDLE, PENDING):
//   - IDLE: cfg_ready=1. On cfg_valid: latch cfg_chan/cfg_period -> PENDING. cfg_chan>=NCH:
//     request accepted and dropped (no commit, cfg_done still pulses, back to IDLE).
//   - PENDING: cfg_ready=0, new requests stalled (valid must be held by requester).
//     Target enabled: commit on the cycle its cnt==period: normal wrap with OLD period
//       (tick, toggle, cnt<=0) AND period<=new value; new P governs from the following count.
//     Target disabled: commit next cycle; period<=new, cnt stays 0.
//     Commit cycle: cfg_done<=1 (registered, one cycle), FSM->IDLE; cfg_ready=1 the cycle after.
//   - Target enable dropped while PENDING: commit on the next cycle (disabled rule).
//  cfg_ready is a pure function of FSM state (registered). Other channels never affected by a commit.
//  Only one request in flight; throughput at most one commit per wrap of the target channel.
// TESTING
//  1 Reset defaults: RESET pulse, chan_en=4'b0001 -> tick[0] every 2500 cycles, clk_out[0] 20 kHz
//    (high 2500 / low 2500 cycles); ch1-3 clk_out=0, tick=0.
//  2 Glitch-free update: ch0 P=9, write P=3 at cnt=4 -> remaining half-period 10 cycles, then
//    4-cycle half-periods; cfg_done single pulse on commit cycle+1; cfg_ready low throughout.
//  3 Disabled target: chan_en[2]=0, write ch2 P=0 -> cfg_done 2 cycles after handshake; enable ->
//    clk_out[2] toggles every cycle, tick[2] stays 1.
//  4 Back-pressure: hold cfg_valid with 2 requests to ch1 (P=5, then P=7) -> second accepted only
//    after first cfg_done; final period 7 (16-cycle clk_out).
//  5 Reset mid-operation: assert RESET while PENDING -> outputs zero same cycle, cfg_ready=1,
//    period restored to 2499, no cfg_done.
//  6 Bad channel: NCH=4 build with 3-bit cfg_chan=5 -> cfg_done pulses, all periods unchanged.

Source files
------------

// File: rtl/clk_div_scheduler.sv
// Programmable clock-divider bank: NCH divide-by-2(P+1) channels whose periods are
// reprogrammed through a valid/ready port and applied only at the channel's wrap boundary.
module clk_div_scheduler #(
    parameter int              NCH            = 4,
    parameter int              WIDTH          = 32,
    parameter longint unsigned DEFAULT_PERIOD = 64'd2499,
    parameter int              CHAN_W         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [NCH-1:0]    chan_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHAN_W-1:0] cfg_chan,
    input  logic [WIDTH-1:0]  cfg_period,
    output logic              cfg_done,
    output logic [NCH-1:0]    tick,
    output logic [NCH-1:0]    clk_out
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);
    localparam logic [WIDTH-1:0] PER_RST  = WIDTH'(DEFAULT_PERIOD);

    logic [WIDTH-1:0]  cnt_q    [NCH];
    logic [WIDTH-1:0]  cnt_d    [NCH];
    logic [WIDTH-1:0]  period_q [NCH];
    logic [WIDTH-1:0]  period_d [NCH];
    logic [NCH-1:0]    clk_out_q, clk_out_d;
    logic [NCH-1:0]    tick_q, tick_d;
    logic [NCH-1:0]    wrap_s;
    state_e            state_q, state_d;
    logic [CHAN_W-1:0] pend_chan_q, pend_chan_d;
    logic [WIDTH-1:0]  pend_period_q, pend_period_d;
    logic              cfg_done_q, cfg_done_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              chan_ok_s;
    logic              target_en_s;
    logic              target_wrap_s;
    logic              commit_s;

    // Out-of-range channel requests are accepted but never committed.
    assign chan_ok_s = ({1'b0, cfg_chan} < (CHAN_W + 1)'(NCH));

    // Per-channel wrap detect and state of the pending request's target channel.
    always_comb begin
        target_en_s   = 1'b0;
        target_wrap_s = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            // Wrapping on >= keeps a counter above a shrunken period from running away.
            wrap_s[i]     = chan_en[i] & (cnt_q[i] >= period_q[i]);
            target_en_s   = target_en_s   | (chan_en[i] & (pend_chan_q == CHAN_W'(i)));
            target_wrap_s = target_wrap_s | (wrap_s[i]  & (pend_chan_q == CHAN_W'(i)));
        end
    end

    // Config FSM next state: one request in flight, committed at the target's wrap.
    always_comb begin
        state_d       = state_q;
        pend_chan_d   = pend_chan_q;
        pend_period_d = pend_period_q;
        cfg_done_d    = 1'b0;
        commit_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    pend_chan_d   = cfg_chan;
                    pend_period_d = cfg_period;
                    if (chan_ok_s) begin
                        state_d = ST_PENDING;
                    end else begin
                        cfg_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (!target_en_s || target_wrap_s) begin
                    commit_s   = 1'b1;
                    cfg_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cfg_ready_d = (state_d == ST_IDLE);
    end

    // Channel counters, outputs and period commit; a commit wraps with the old period.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            clk_out_d[i] = clk_out_q[i];
            tick_d[i]    = 1'b0;
            if (!chan_en[i]) begin
                cnt_d[i] = CNT_ZERO;
            end else if (wrap_s[i]) begin
                cnt_d[i]     = CNT_ZERO;
                clk_out_d[i] = ~clk_out_q[i];
                tick_d[i]    = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
            if (commit_s && (pend_chan_q == CHAN_W'(i))) begin
                period_d[i] = pend_period_q;
            end else begin
                period_d[i] = period_q[i];
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]    <= CNT_ZERO;
                period_q[i] <= PER_RST;
            end
            clk_out_q     <= {NCH{1'b0}};
            tick_q        <= {NCH{1'b0}};
            state_q       <= ST_IDLE;
            pend_chan_q   <= {CHAN_W{1'b0}};
            pend_period_q <= CNT_ZERO;
            cfg_done_q    <= 1'b0;
            cfg_ready_q   <= 1'b1;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                period_q[i] <= period_d[i];
            end
            clk_out_q     <= clk_out_d;
            tick_q        <= tick_d;
            state_q       <= state_d;
            pend_chan_q   <= pend_chan_d;
            pend_period_q <= pend_period_d;
            cfg_done_q    <= cfg_done_d;
            cfg_ready_q   <= cfg_ready_d;
        end
    end

    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_ready = cfg_ready_q;

endmodule
